// File: rtl/cpu_pkg.sv
// Shared fetch/decode types: halfword and word aliases, NOP encoding,
// and the queued fetch entry (instruction halfword plus its byte address).
package cpu_pkg;

   typedef logic [15:0] hword_t;
   typedef logic [31:0] word_t;

   localparam hword_t NOP_IR = 16'hBF00;

   typedef struct packed {
      hword_t ir;
      word_t  pc;
   } fetch_ent_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch halfword FIFO: two-wide push (lo then hi), one-wide pop,
// synchronous flush; QDEPTH need not be a power of two.
module fetch_queue
   import cpu_pkg::*;
#(
   parameter  int QDEPTH = 4,
   localparam int AW     = $clog2(QDEPTH),
   localparam int CW     = $clog2(QDEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_flush,
   input  logic          i_push_lo,
   input  logic          i_push_hi,
   input  fetch_ent_t    i_lo,
   input  fetch_ent_t    i_hi,
   input  logic          i_pop,
   output fetch_ent_t    o_head,
   output logic [CW-1:0] o_count
);

   fetch_ent_t    r_mem [QDEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [CW-1:0] r_count;
   logic [AW-1:0] w_hi_idx;
   logic [CW-1:0] w_npush;

   function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
      return (p == AW'(QDEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // hi lands after lo when both arrive, otherwise in the lo slot
   assign w_hi_idx = i_push_lo ? inc(r_wp) : r_wp;
   assign w_npush  = CW'(i_push_lo) + CW'(i_push_hi);

   always_ff @(posedge clk) begin
      if (i_push_lo) r_mem[r_wp]     <= i_lo;
      if (i_push_hi) r_mem[w_hi_idx] <= i_hi;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
      end else begin
         if (i_push_lo && i_push_hi)
            r_wp <= inc(inc(r_wp));
         else if (i_push_lo || i_push_hi)
            r_wp <= inc(r_wp);
         if (i_pop)
            r_rp <= inc(r_rp);
         r_count <= r_count + w_npush - CW'(i_pop);
      end
   end

   assign o_head  = r_mem[r_rp];
   assign o_count = r_count;

endmodule

// File: rtl/fetch.sv
// Thumb instruction fetch stage: word requests, halfword prefetch queue, IR.
// FETCH_PERF_CNT_EN adds the saturating o_bubble_cnt output.
module fetch
   import cpu_pkg::*;
#(
   parameter word_t RESET_PC = 32'h0000_0000,
   parameter int    QDEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_stall,
   input  logic        i_branch,
   input  word_t       i_branch_addr,
   output logic        o_imem_req,
   output word_t       o_imem_addr,
   input  logic        i_imem_ack,
   input  word_t       i_imem_rdata,
   output hword_t      o_ir,
   output word_t       o_ir_pc,
   output logic        o_ir_valid
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] o_bubble_cnt
`endif
);

   localparam int CW = $clog2(QDEPTH + 1);

   logic          r_req;
   word_t         r_addr;
   word_t         r_fa;
   logic          r_skip;
   logic          r_disc;
   hword_t        r_ir;
   word_t         r_pc;
   logic          r_valid;

   logic          w_ack;
   logic          w_push;
   logic          w_pop;
   logic          w_empty;
   logic          w_issue;
   logic [CW-1:0] w_count;
   fetch_ent_t    w_lo;
   fetch_ent_t    w_hi;
   fetch_ent_t    w_head;

   assign w_ack   = i_imem_ack & r_req;
   assign w_push  = w_ack & ~r_disc & ~i_branch;
   assign w_empty = (w_count == '0);
   assign w_pop   = ~i_branch & ~i_stall & ~w_empty;
   // two free slots guarantee room for a whole word on ack
   assign w_issue = ~r_req & ~i_branch & (w_count <= CW'(QDEPTH - 2));
   assign w_lo    = {i_imem_rdata[15:0], r_addr};
   assign w_hi    = {i_imem_rdata[31:16], r_addr | 32'd2};

   fetch_queue #(.QDEPTH(QDEPTH)) u_q (
      .clk       (clk),
      .rst       (rst),
      .i_flush   (i_branch),
      .i_push_lo (w_push & ~r_skip),
      .i_push_hi (w_push),
      .i_lo      (w_lo),
      .i_hi      (w_hi),
      .i_pop     (w_pop),
      .o_head    (w_head),
      .o_count   (w_count)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_req  <= 1'b0;
         r_addr <= RESET_PC & ~32'h3;
         r_fa   <= RESET_PC & ~32'h3;
         r_skip <= RESET_PC[1];
         r_disc <= 1'b0;
      end else begin
         if (w_ack) begin
            r_req  <= 1'b0;
            r_disc <= 1'b0;
         end else if (w_issue) begin
            r_req  <= 1'b1;
            r_addr <= r_fa;
         end
         if (i_branch) begin
            r_fa   <= i_branch_addr & ~32'h3;
            r_skip <= i_branch_addr[1];
            // in-flight word belongs to the old stream
            if (r_req && !i_imem_ack) r_disc <= 1'b1;
         end else if (w_push) begin
            r_fa   <= r_fa + 32'd4;
            r_skip <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ir    <= NOP_IR;
         r_pc    <= RESET_PC;
         r_valid <= 1'b0;
      end else if (i_branch) begin
         r_ir    <= NOP_IR;
         r_valid <= 1'b0;
      end else if (i_stall) begin
         r_ir    <= r_ir;
      end else if (!w_empty) begin
         r_ir    <= w_head.ir;
         r_pc    <= w_head.pc;
         r_valid <= 1'b1;
      end else begin
         r_ir    <= NOP_IR;
         r_valid <= 1'b0;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_bub;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_bub <= '0;
      else if (!i_branch && !i_stall && w_empty && r_bub != 32'hFFFF_FFFF)
         r_bub <= r_bub + 32'd1;
   end

   assign o_bubble_cnt = r_bub;
`endif

   assign o_imem_req  = r_req;
   assign o_imem_addr = r_addr;
   assign o_ir        = r_ir;
   assign o_ir_pc     = r_pc;
   assign o_ir_valid  = r_valid;

endmodule

// File: tb/tb_fetch.sv
// Directed and randomized bench for fetch against a queue-level model
// of the instruction stream, memory handshake and bubble count.
module tb_fetch;
   import cpu_pkg::*;

   localparam word_t RPC = 32'h0000_0000;
   localparam int    QD  = 4;

   logic   clk = 1'b0;
   logic   rst = 1'b0;
   logic   stall = 1'b0;
   logic   br = 1'b0;
   word_t  br_addr = '0;
   logic   req;
   word_t  addr;
   logic   ack = 1'b0;
   word_t  rdata = '0;
   hword_t ir;
   word_t  irpc;
   logic   irv;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] bub;
`endif

   always #5 clk = ~clk;

   fetch #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_stall       (stall),
      .i_branch      (br),
      .i_branch_addr (br_addr),
      .o_imem_req    (req),
      .o_imem_addr   (addr),
      .i_imem_ack    (ack),
      .i_imem_rdata  (rdata),
      .o_ir          (ir),
      .o_ir_pc       (irpc),
      .o_ir_valid    (irv)
`ifdef FETCH_PERF_CNT_EN
      ,
      .o_bubble_cnt  (bub)
`endif
   );

   int tests = 0;
   int fails = 0;

   // model state: queue of pending halfword byte addresses
   word_t       mq[$];
   hword_t      m_ir;
   word_t       m_pc;
   logic        m_v;
   word_t       m_fa;
   logic        m_skip;
   logic        m_pend;
   logic        m_disc;
   word_t       m_raddr;
   logic [31:0] m_bub;
   int          lat = 1;
   int          mcnt = 0;

   function automatic word_t mem_word(input word_t a);
      if (a == 32'h0) return 32'h2001_1C48;
      return (a * 32'h9E37_79B1) ^ (a >> 5) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic hword_t half(input word_t pc);
      word_t w;
      w = mem_word({pc[31:2], 2'b00});
      return pc[1] ? w[31:16] : w[15:0];
   endfunction

   task automatic chk(input string tag, input word_t obs, input word_t exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_ir    = NOP_IR;
      m_v     = 1'b0;
      m_pc    = RPC;
      m_fa    = RPC & ~32'h3;
      m_skip  = RPC[1];
      m_pend  = 1'b0;
      m_disc  = 1'b0;
      m_raddr = m_fa;
      m_bub   = '0;
   endtask

   // apply the spec's per-cycle rules to the inputs about to be sampled
   task automatic model_edge();
      int   sz;
      logic acke;
      sz   = mq.size();
      acke = ack && m_pend;
      if (br) begin
         m_ir = NOP_IR;
         m_v  = 1'b0;
      end else if (stall) begin
         m_v = m_v;
      end else if (sz > 0) begin
         m_pc = mq.pop_front();
         m_ir = half(m_pc);
         m_v  = 1'b1;
      end else begin
         m_ir = NOP_IR;
         m_v  = 1'b0;
         if (m_bub != 32'hFFFF_FFFF) m_bub++;
      end
      if (acke) begin
         if (!m_disc && !br) begin
            if (!m_skip) mq.push_back(m_fa);
            mq.push_back(m_fa + 32'd2);
            m_fa   = m_fa + 32'd4;
            m_skip = 1'b0;
         end
         m_pend = 1'b0;
         m_disc = 1'b0;
      end else if (!m_pend && !br && (QD - sz) >= 2) begin
         m_pend  = 1'b1;
         m_raddr = m_fa;
      end
      if (br) begin
         mq.delete();
         m_fa   = br_addr & ~32'h3;
         m_skip = br_addr[1];
         if (m_pend) m_disc = 1'b1;
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      if (ack) begin
         ack   = 1'b0;
         mcnt  = 0;
         rdata = $urandom;
      end else if (req) begin
         mcnt++;
         if (mcnt >= lat) begin
            ack   = 1'b1;
            rdata = mem_word(addr);
         end
      end else begin
         rdata = $urandom;
      end
      chk("ir", 32'(ir), 32'(m_ir));
      chk("ir_pc", irpc, m_pc);
      chk("ir_valid", 32'(irv), 32'(m_v));
      chk("imem_req", 32'(req), 32'(m_pend));
      if (m_pend) chk("imem_addr", addr, m_raddr);
`ifdef FETCH_PERF_CNT_EN
      chk("bubble_cnt", bub, m_bub);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog tests=%0d", tests);
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ir", 32'(ir), 32'(NOP_IR));
      chk("rst_valid", 32'(irv), 32'h0);
      chk("rst_pc", irpc, RPC);
      chk("rst_req", 32'(req), 32'h0);
      #2 rst = 1'b1;

      // basic stream from address 0 with 1-cycle memory
      lat = 1;
      step();
      chk("first_req", 32'(req), 32'h1);
      chk("first_req_addr", addr, 32'h0);
      step();
      step();
      chk("ir0", 32'(ir), 32'h1C48);
      chk("ir0_pc", irpc, 32'h0);
      chk("ir0_valid", 32'(irv), 32'h1);

      // stall holds the IR while the queue keeps filling
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_ir", 32'(ir), 32'h1C48);
         chk("stall_pc", irpc, 32'h0);
      end
      stall = 1'b0;
      step();
      chk("ir1", 32'(ir), 32'h2001);
      chk("ir1_pc", irpc, 32'h2);

      // branch while a slow request is pending
      lat = 4;
      for (int i = 0; i < 20 && !(req && !ack); i++) step();
      chk("pend_before_br", 32'({req, ack}), 32'h2);
      br = 1'b1;
      br_addr = 32'h0000_0102;
      step();
      br = 1'b0;
      chk("br_ir", 32'(ir), 32'(NOP_IR));
      chk("br_valid", 32'(irv), 32'h0);
      for (int i = 0; i < 20 && req; i++) step();
      chk("stale_ack_done", 32'(req), 32'h0);
      for (int i = 0; i < 20 && !req; i++) step();
      chk("br_req_addr", addr, 32'h0000_0100);
      for (int i = 0; i < 20 && !irv; i++) step();
      chk("br_first_ir", 32'(ir), 32'(half(32'h102)));
      chk("br_first_pc", irpc, 32'h0000_0102);

      // branch and stall together: branch wins
      repeat (4) step();
      stall = 1'b1;
      br = 1'b1;
      br_addr = $urandom;
      step();
      chk("brstall_valid", 32'(irv), 32'h0);
      chk("brstall_ir", 32'(ir), 32'(NOP_IR));
      stall = 1'b0;
      br = 1'b0;

      // long memory latency produces bubbles between words
      lat = 5;
      repeat (40) step();

      // fetch address wraps past the top of memory
      lat = 1;
      br = 1'b1;
      br_addr = 32'hFFFF_FFFE;
      step();
      br = 1'b0;
      for (int i = 0; i < 20 && !irv; i++) step();
      chk("wrap_first_pc", irpc, 32'hFFFF_FFFE);
      repeat (12) step();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         stall   = ($urandom % 4) == 0;
         br      = ($urandom % 20) == 0;
         br_addr = $urandom;
         lat     = 1 + ($urandom % 4);
         step();
      end
      stall = 1'b0;
      br = 1'b0;

      // asynchronous reset in the middle of a request
      lat = 3;
      for (int i = 0; i < 20 && !(req && !ack); i++) step();
      #3 rst = 1'b0;
      #1;
      chk("arst_ir", 32'(ir), 32'(NOP_IR));
      chk("arst_valid", 32'(irv), 32'h0);
      chk("arst_pc", irpc, RPC);
      chk("arst_req", 32'(req), 32'h0);
      ack = 1'b0;
      mcnt = 0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #4 rst = 1'b1;
      ack = 1'b1;
      rdata = 32'hDEAD_BEEF;
      step();
      chk("arst_req_after", 32'(req), 32'h1);
      chk("arst_req_addr", addr, RPC & ~32'h3);
      repeat (20) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
